// File: rtl/sd_sched_ctrl.sv
// sd_sched_ctrl: per-stage start-delay / firing-interval scheduler
// driven by a saturating global counter, with an IDLE/RUN/DONE controller.
//
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-low reset
//   stall    in  freezes counters and masks fire while in RUN
//   start    in  launches a run when sampled in IDLE
//   n_items  in  firings per stage, latched on launch
//   fire     out per-stage fire strobe (combinational)
//   gl_cntr  out global schedule counter
//   busy     out high in RUN
//   done     out one-cycle pulse on run completion
//   err      out sticky order-violation flag
//
// Build option SD_SCHED_ORDER_CHK_EN: enables the stage-order
// checker on err; when undefined err is tied low.
module sd_sched_ctrl #(
   parameter int GL_CNTR_W = 16,
   parameter int NSTAGES   = 4,
   parameter int FI_W      = 4,
   parameter logic [NSTAGES*GL_CNTR_W-1:0] SD_VEC =
      {16'd12, 16'd2, 16'd1, 16'd0},
   parameter logic [NSTAGES*FI_W-1:0] FI_VEC =
      {4'd10, 4'd1, 4'd1, 4'd1}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 start,
   input  logic [GL_CNTR_W-1:0] n_items,
   output logic [NSTAGES-1:0]   fire,
   output logic [GL_CNTR_W-1:0] gl_cntr,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e state_q, state_d;

   logic [GL_CNTR_W-1:0] gl_q, gl_d;
   logic [GL_CNTR_W-1:0] n_q, n_d;
   logic [GL_CNTR_W-1:0] cnt_q [NSTAGES];
   logic [GL_CNTR_W-1:0] cnt_d [NSTAGES];
   logic [FI_W-1:0]      ivl_q [NSTAGES];
   logic [FI_W-1:0]      ivl_d [NSTAGES];

   logic [GL_CNTR_W-1:0] sd_c    [NSTAGES];
   logic [FI_W-1:0]      fi_ld_c [NSTAGES];

   logic [NSTAGES-1:0] fire_c;
   logic               adv;
   logic               all_fired;

   // Reload value after a fire is FI-1; an interval of 0 acts as 1.
   for (genvar g = 0; g < NSTAGES; g++) begin : g_cfg
      localparam logic [FI_W-1:0] FI = FI_VEC[g*FI_W +: FI_W];
      assign sd_c[g]    = SD_VEC[g*GL_CNTR_W +: GL_CNTR_W];
      assign fi_ld_c[g] = (FI == '0) ? '0 : FI - FI_W'(1);
   end

   always_comb begin
      adv = (state_q == RUN) && !stall;
      for (int i = 0; i < NSTAGES; i++) begin
         fire_c[i] = adv
                   && (gl_q >= sd_c[i])
                   && (ivl_q[i] == '0)
                   && (cnt_q[i] < n_q);
         cnt_d[i] = cnt_q[i] + GL_CNTR_W'(fire_c[i]);
         if (fire_c[i]) begin
            ivl_d[i] = fi_ld_c[i];
         end else if (adv && (ivl_q[i] != '0)) begin
            ivl_d[i] = ivl_q[i] - FI_W'(1);
         end else begin
            ivl_d[i] = ivl_q[i];
         end
      end

      // Leave RUN in the same cycle as the last stage's final fire.
      all_fired = 1'b1;
      for (int i = 0; i < NSTAGES; i++) begin
         if (cnt_d[i] != n_q) begin
            all_fired = 1'b0;
         end
      end

      gl_d = (adv && (gl_q != '1)) ? gl_q + GL_CNTR_W'(1) : gl_q;
      n_d     = n_q;
      state_d = state_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (n_items != '0) begin
                  state_d = RUN;
                  gl_d    = '0;
                  n_d     = n_items;
                  for (int i = 0; i < NSTAGES; i++) begin
                     cnt_d[i] = '0;
                     ivl_d[i] = '0;
                  end
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (all_fired) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         gl_q    <= '0;
         n_q     <= '0;
         for (int i = 0; i < NSTAGES; i++) begin
            cnt_q[i] <= '0;
            ivl_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         gl_q    <= gl_d;
         n_q     <= n_d;
         for (int i = 0; i < NSTAGES; i++) begin
            cnt_q[i] <= cnt_d[i];
            ivl_q[i] <= ivl_d[i];
         end
      end
   end

`ifdef SD_SCHED_ORDER_CHK_EN
   logic err_q, err_d;
   logic viol;

   // A stage may never get ahead of its upstream neighbour,
   // compared on post-fire counts so simultaneous fires are legal.
   always_comb begin
      viol = 1'b0;
      for (int i = 1; i < NSTAGES; i++) begin
         if (fire_c[i] && (cnt_d[i] > cnt_d[i-1])) begin
            viol = 1'b1;
         end
      end
      err_d = err_q | viol;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign fire    = fire_c;
   assign gl_cntr = gl_q;
   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);

endmodule

// File: tb/tb_sd_sched_ctrl.sv
// tb_sd_sched_ctrl: three schedule configurations driven in lockstep,
// checked against fire times derived from SD + k*FI arithmetic.
module tb_sd_sched_ctrl;
   localparam int W = 16;

`ifdef SD_SCHED_ORDER_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         stall;
   logic         start;
   logic [W-1:0] n_items;

   logic [3:0]   fire_w [3];
   logic [W-1:0] gl_w   [3];
   logic         busy_w [3];
   logic         done_w [3];
   logic         err_w  [3];

   int checks   = 0;
   int failures = 0;
   int sd [3][4];
   int fi [3][4];
   bit eerr [3];
   int busy_a;

   always #5 clk = ~clk;

   sd_sched_ctrl #(
      .SD_VEC({16'd3, 16'd2, 16'd1, 16'd0}),
      .FI_VEC({4'd1, 4'd1, 4'd1, 4'd1})
   ) u_a (
      .clk(clk), .rst(rst), .stall(stall), .start(start),
      .n_items(n_items), .fire(fire_w[0]), .gl_cntr(gl_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0])
   );

   sd_sched_ctrl u_b (
      .clk(clk), .rst(rst), .stall(stall), .start(start),
      .n_items(n_items), .fire(fire_w[1]), .gl_cntr(gl_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1])
   );

   sd_sched_ctrl #(
      .SD_VEC({16'd0, 16'd0, 16'd0, 16'd3}),
      .FI_VEC({4'd1, 4'd1, 4'd1, 4'd1})
   ) u_c (
      .clk(clk), .rst(rst), .stall(stall), .start(start),
      .n_items(n_items), .fire(fire_w[2]), .gl_cntr(gl_w[2]),
      .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2])
   );

   function automatic int fiv(int d, int i);
      return (fi[d][i] == 0) ? 1 : fi[d][i];
   endfunction

   // Stage i fires at schedule times sd + k*fi for k < n.
   function automatic bit fires(int d, int i, int t, int n);
      int k;
      if (t < sd[d][i]) return 1'b0;
      if (((t - sd[d][i]) % fiv(d, i)) != 0) return 1'b0;
      k = (t - sd[d][i]) / fiv(d, i);
      return k < n;
   endfunction

   function automatic int cnt_at(int d, int i, int t, int n);
      int c;
      if (t < sd[d][i]) return 0;
      c = (t - sd[d][i]) / fiv(d, i) + 1;
      return (c > n) ? n : c;
   endfunction

   function automatic int t_last(int d, int n);
      int m = 0;
      for (int i = 0; i < 4; i++) begin
         if (sd[d][i] + (n - 1) * fiv(d, i) > m)
            m = sd[d][i] + (n - 1) * fiv(d, i);
      end
      return m;
   endfunction

   task automatic run(input int n, input int st_t, input int st_len,
                      input int ab_t, input bit rnd);
      int t;
      int slen;
      bit stl;
      bit fin [3];
      bit dn  [3];
      bit all_dn;
      logic [3:0]   ef;
      logic         eb;
      logic         ed;
      logic [W-1:0] eg;
      busy_a = 0;
      start   = 1'b1;
      n_items = W'(n);
      stall   = rnd ? 1'($urandom % 2) : 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0
             || fire_w[d] !== 4'h0 || err_w[d] !== eerr[d]) begin
            failures++;
            $display("FAIL idle dut%0d got b=%b d=%b f=%h e=%b exp 0 0 0 %b",
                     d, busy_w[d], done_w[d], fire_w[d], err_w[d], eerr[d]);
         end
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 0) begin
         stall = rnd ? 1'($urandom % 2) : 1'b0;
         #1;
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (done_w[d] !== 1'b1 || busy_w[d] !== 1'b0
                || fire_w[d] !== 4'h0) begin
               failures++;
               $display("FAIL zero_done dut%0d got d=%b b=%b f=%h exp 1 0 0",
                        d, done_w[d], busy_w[d], fire_w[d]);
            end
         end
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (done_w[d] !== 1'b0 || busy_w[d] !== 1'b0) begin
               failures++;
               $display("FAIL zero_idle dut%0d got d=%b b=%b exp 0 0",
                        d, done_w[d], busy_w[d]);
            end
         end
         return;
      end
      t = 0;
      slen = 0;
      fin = '{1'b0, 1'b0, 1'b0};
      dn  = '{1'b0, 1'b0, 1'b0};
      for (int cy = 0; cy < 400; cy++) begin
         if (st_t >= 0 && t == st_t && slen < st_len) stl = 1'b1;
         else if (rnd) stl = ($urandom % 4) == 0;
         else stl = 1'b0;
         stall = stl;
         start = (rnd && !dn[0] && !dn[1] && !dn[2])
                 ? 1'($urandom % 2) : 1'b0;
         #1;
         for (int d = 0; d < 3; d++) begin
            ef = 4'h0;
            if (!fin[d]) begin
               if (!stl)
                  for (int i = 0; i < 4; i++) ef[i] = fires(d, i, t, n);
               eb = 1'b1;
               ed = 1'b0;
            end else begin
               eb = 1'b0;
               ed = !dn[d];
            end
            eg = W'(t);
            checks++;
            if (fire_w[d] !== ef) begin
               failures++;
               $display("FAIL fire dut%0d t=%0d got=%h exp=%h",
                        d, t, fire_w[d], ef);
            end
            checks++;
            if (busy_w[d] !== eb) begin
               failures++;
               $display("FAIL busy dut%0d t=%0d got=%b exp=%b",
                        d, t, busy_w[d], eb);
            end
            checks++;
            if (done_w[d] !== ed) begin
               failures++;
               $display("FAIL done dut%0d t=%0d got=%b exp=%b",
                        d, t, done_w[d], ed);
            end
            checks++;
            if (err_w[d] !== eerr[d]) begin
               failures++;
               $display("FAIL err dut%0d t=%0d got=%b exp=%b",
                        d, t, err_w[d], eerr[d]);
            end
            if (!fin[d]) begin
               checks++;
               if (gl_w[d] !== eg) begin
                  failures++;
                  $display("FAIL gl_cntr dut%0d got=%0d exp=%0d",
                           d, gl_w[d], eg);
               end
               if (d == 0) busy_a++;
            end
            if (fin[d]) dn[d] = 1'b1;
         end
         if (ab_t >= 0 && t == ab_t) begin
            rst = 1'b0;
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
               checks++;
               if (fire_w[d] !== 4'h0 || busy_w[d] !== 1'b0
                   || done_w[d] !== 1'b0 || gl_w[d] !== '0
                   || err_w[d] !== 1'b0) begin
                  failures++;
                  $display("FAIL abort dut%0d got f=%h b=%b d=%b g=%0d e=%b exp all 0",
                           d, fire_w[d], busy_w[d], done_w[d], gl_w[d], err_w[d]);
               end
            end
            rst = 1'b1;
            start = 1'b0;
            stall = 1'b0;
            eerr = '{1'b0, 1'b0, 1'b0};
            return;
         end
         if (!stl) begin
            for (int d = 0; d < 3; d++) begin
               if (!fin[d]) begin
                  for (int i = 1; i < 4; i++) begin
                     if (CHK && fires(d, i, t, n)
                         && cnt_at(d, i, t, n) > cnt_at(d, i - 1, t, n))
                        eerr[d] = 1'b1;
                  end
                  if (t == t_last(d, n)) fin[d] = 1'b1;
               end
            end
            t++;
         end else if (st_t >= 0 && t == st_t) begin
            slen++;
         end
         @(posedge clk); #1;
         all_dn = dn[0] && dn[1] && dn[2];
         if (all_dn) begin
            start = 1'b0;
            stall = 1'b0;
            return;
         end
      end
      failures++;
      $display("FAIL timeout n=%0d run did not complete", n);
      start = 1'b0;
      stall = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (fire_w[d] !== 4'h0 || busy_w[d] !== 1'b0
             || done_w[d] !== 1'b0 || gl_w[d] !== '0
             || err_w[d] !== 1'b0) begin
            failures++;
            $display("FAIL reset dut%0d got f=%h b=%b d=%b g=%0d e=%b exp all 0",
                     d, fire_w[d], busy_w[d], done_w[d], gl_w[d], err_w[d]);
         end
      end
      eerr = '{1'b0, 1'b0, 1'b0};
      rst = 1'b1;
   endtask

   task automatic test_basic();
      run(3, -1, 0, -1, 1'b0);
      checks++;
      if (busy_a != 6) begin
         failures++;
         $display("FAIL busy_len got=%0d exp=6", busy_a);
      end
   endtask

   task automatic test_default_sched();
      run(2, -1, 0, -1, 1'b0);
   endtask

   task automatic test_stall();
      run(3, 1, 2, -1, 1'b0);
      checks++;
      if (busy_a != 8) begin
         failures++;
         $display("FAIL stall_busy_len got=%0d exp=8", busy_a);
      end
   endtask

   task automatic test_zero_items();
      run(0, -1, 0, -1, 1'b0);
   endtask

   task automatic test_abort();
      run(3, -1, 0, 4, 1'b0);
      run(3, -1, 0, -1, 1'b0);
   endtask

   task automatic test_order_err();
      run(1, -1, 0, -1, 1'b0);
      checks++;
      if (err_w[2] !== CHK || err_w[0] !== 1'b0 || err_w[1] !== 1'b0) begin
         failures++;
         $display("FAIL order_err got c=%b a=%b b=%b exp c=%b a=0 b=0",
                  err_w[2], err_w[0], err_w[1], CHK);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (err_w[2] !== 1'b0) begin
         failures++;
         $display("FAIL err_clear got=%b exp=0", err_w[2]);
      end
      rst = 1'b1;
      eerr = '{1'b0, 1'b0, 1'b0};
   endtask

   task automatic test_random();
      int n;
      int ab;
      for (int k = 0; k < 30; k++) begin
         n  = $urandom_range(0, 5);
         ab = (($urandom % 4) == 0) ? int'($urandom % 20) : -1;
         run(n, -1, 0, ab, 1'b1);
      end
   endtask

   initial begin
      sd = '{'{0, 1, 2, 3}, '{0, 1, 2, 12}, '{3, 0, 0, 0}};
      fi = '{'{1, 1, 1, 1}, '{1, 1, 1, 10}, '{1, 1, 1, 1}};
      eerr = '{1'b0, 1'b0, 1'b0};
      rst = 1'b0;
      stall = 1'b0;
      start = 1'b0;
      n_items = '0;
      test_reset();
      test_basic();
      test_default_sched();
      test_stall();
      test_zero_items();
      test_abort();
      test_order_err();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
